// File: rtl/dts_align_ctrl.sv
// dts_align_ctrl: measures each stream's sync phase against stream 0 and pulses advance/delay until all coincide.
// Build option DTS_ALIGN_CTRL_AUTORELOCK_EN: a sync mismatch while locked triggers a fresh alignment pass.
module dts_align_ctrl #(
    parameter int N_STREAMS       = 4,
    parameter int MUX_FACTOR_BITS = 0,
    parameter int SYNC_PERIOD     = 1024,
    parameter int MAX_SLIP        = 12,
    parameter int PULSE_LEN       = 4,
    parameter int SETTLE_CYCLES   = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [N_STREAMS-1:0]         sync,
    output logic [N_STREAMS-1:0]         advance,
    output logic [N_STREAMS-1:0]         delay,
    output logic                         aligned,
    output logic                         fault,
    output logic [$clog2(N_STREAMS)-1:0] fault_stream,
    output logic [15:0]                  corrections
);
    localparam int STEP = 1 << MUX_FACTOR_BITS;
    localparam int CW   = $clog2(SYNC_PERIOD);
    localparam int TMAX = (2 * SYNC_PERIOD > SETTLE_CYCLES) ? 2 * SYNC_PERIOD : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam int KW   = $clog2(MAX_SLIP + 1);
    localparam int PW   = $clog2(2 * PULSE_LEN);
    localparam int SW   = $clog2(N_STREAMS);

    localparam logic [CW-1:0] HALF      = CW'(SYNC_PERIOD / 2);
    localparam logic [CW:0]   SP_W      = (CW + 1)'(SYNC_PERIOD);
    localparam logic [CW:0]   STEP_MASK = (CW + 1)'(STEP - 1);
    localparam logic [CW:0]   SLIP_LIM  = (CW + 1)'(MAX_SLIP);
    localparam logic [PW-1:0] PL_W      = PW'(PULSE_LEN);
    localparam logic [PW-1:0] PT_END    = PW'(2 * PULSE_LEN - 1);
    localparam logic [TW-1:0] REF_TMO   = TW'(2 * SYNC_PERIOD - 1);
    localparam logic [TW-1:0] MEAS_END  = TW'(SYNC_PERIOD - 1);
    localparam logic [TW-1:0] SETL_END  = TW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_REF, S_MEASURE, S_DECODE, S_CORRECT, S_SETTLE, S_LOCKED, S_FAULT
    } state_t;

    state_t               state;
    logic [TW-1:0]        timer;
    logic [PW-1:0]        pt;
    logic [N_STREAMS-1:1] seen;
    logic [N_STREAMS-1:1] dir_adv;
    logic [CW-1:0]        phase [N_STREAMS-1:1];
    logic [KW-1:0]        cnt   [N_STREAMS-1:1];

    logic [KW-1:0]        dec_cnt [N_STREAMS-1:1];
    logic [N_STREAMS-1:1] dec_adv;
    logic                 dec_bad;
    logic                 dec_zero;
    logic [SW-1:0]        dec_stream;
    logic [CW:0]          off;
    logic [N_STREAMS-1:1] active;
    logic [SW:0]          n_active;
    logic                 all_last;
    logic [16:0]          corr_sum;

    // Phase below half a period means the stream lags the reference; above means it leads.
    always_comb begin
        dec_bad    = 1'b0;
        dec_zero   = 1'b1;
        dec_stream = '0;
        dec_adv    = '0;
        off        = '0;
        for (int unsigned i = 1; i < N_STREAMS; i++) begin
            if (phase[i] < HALF) begin
                off        = {1'b0, phase[i]};
                dec_adv[i] = 1'b1;
            end else begin
                off = SP_W - {1'b0, phase[i]};
            end
            dec_cnt[i] = KW'(off >> MUX_FACTOR_BITS);
            if (!seen[i] || (off & STEP_MASK) != '0 || (off >> MUX_FACTOR_BITS) > SLIP_LIM) begin
                if (!dec_bad) dec_stream = SW'(i);
                dec_bad = 1'b1;
            end
            if (off != '0) dec_zero = 1'b0;
        end
    end

    always_comb begin
        n_active = '0;
        all_last = 1'b1;
        for (int unsigned i = 1; i < N_STREAMS; i++) begin
            active[i] = (cnt[i] != '0);
            if (active[i]) n_active = n_active + 1'b1;
            if (cnt[i] > KW'(1)) all_last = 1'b0;
        end
        corr_sum = {1'b0, corrections} + 17'(n_active);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            timer        <= '0;
            pt           <= '0;
            seen         <= '0;
            dir_adv      <= '0;
            advance      <= '0;
            delay        <= '0;
            aligned      <= 1'b0;
            fault        <= 1'b0;
            fault_stream <= '0;
            corrections  <= '0;
            for (int unsigned i = 1; i < N_STREAMS; i++) begin
                phase[i] <= '0;
                cnt[i]   <= '0;
            end
        end else if (!enable) begin
            state   <= S_IDLE;
            timer   <= '0;
            pt      <= '0;
            advance <= '0;
            delay   <= '0;
            aligned <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    timer <= '0;
                    state <= S_WAIT_REF;
                end
                S_WAIT_REF: begin
                    if (sync[0]) begin
                        seen  <= sync[N_STREAMS-1:1];
                        for (int unsigned i = 1; i < N_STREAMS; i++) phase[i] <= '0;
                        timer <= TW'(1);
                        state <= S_MEASURE;
                    end else if (timer == REF_TMO) begin
                        if (!fault) fault_stream <= '0;
                        fault <= 1'b1;
                        state <= S_FAULT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_MEASURE: begin
                    if (sync[0]) begin
                        state <= S_DECODE;
                    end else begin
                        for (int unsigned i = 1; i < N_STREAMS; i++) begin
                            if (sync[i] && !seen[i]) begin
                                seen[i]  <= 1'b1;
                                phase[i] <= CW'(timer);
                            end
                        end
                        timer <= timer + 1'b1;
                        if (timer == MEAS_END) state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec_bad) begin
                        if (!fault) fault_stream <= dec_stream;
                        fault <= 1'b1;
                        state <= S_FAULT;
                    end else if (dec_zero) begin
                        aligned <= 1'b1;
                        state   <= S_LOCKED;
                    end else begin
                        for (int unsigned i = 1; i < N_STREAMS; i++) cnt[i] <= dec_cnt[i];
                        dir_adv <= dec_adv;
                        pt      <= '0;
                        state   <= S_CORRECT;
                    end
                end
                S_CORRECT: begin
                    for (int unsigned i = 1; i < N_STREAMS; i++) begin
                        advance[i] <= active[i] && dir_adv[i] && (pt < PL_W);
                        delay[i]   <= active[i] && !dir_adv[i] && (pt < PL_W);
                    end
                    if (pt == '0) corrections <= corr_sum[16] ? 16'hFFFF : corr_sum[15:0];
                    if (pt == PT_END) begin
                        pt <= '0;
                        for (int unsigned i = 1; i < N_STREAMS; i++) begin
                            if (active[i]) cnt[i] <= cnt[i] - 1'b1;
                        end
                        if (all_last) begin
                            timer <= '0;
                            state <= S_SETTLE;
                        end
                    end else begin
                        pt <= pt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (timer == SETL_END) begin
                        timer <= '0;
                        state <= S_WAIT_REF;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (sync == '1) begin
                        aligned <= 1'b1;
                    end else if (|sync) begin
                        aligned <= 1'b0;
`ifdef DTS_ALIGN_CTRL_AUTORELOCK_EN
                        timer <= '0;
                        state <= S_WAIT_REF;
`endif
                    end
                end
                S_FAULT: begin
                    advance <= '0;
                    delay   <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dts_align_ctrl.sv
// Bench for dts_align_ctrl: two instances (MUX_FACTOR_BITS 0 and 2) driven by a phase model of the offsetters.
module tb_dts_align_ctrl;
    localparam int N  = 4;
    localparam int SP = 64;
    localparam int MS = 12;
    localparam int PL = 4;
    localparam int SC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic [N-1:0] sync_v [2];
    logic [N-1:0] adv_v  [2];
    logic [N-1:0] dly_v  [2];
    logic [1:0]   aligned_v;
    logic [1:0]   fault_v;
    logic [1:0]   fs_v   [2];
    logic [15:0]  corr_v [2];

    dts_align_ctrl #(.N_STREAMS(N), .MUX_FACTOR_BITS(0), .SYNC_PERIOD(SP), .MAX_SLIP(MS),
                     .PULSE_LEN(PL), .SETTLE_CYCLES(SC)) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .sync(sync_v[0]), .advance(adv_v[0]),
        .delay(dly_v[0]), .aligned(aligned_v[0]), .fault(fault_v[0]),
        .fault_stream(fs_v[0]), .corrections(corr_v[0]));

    dts_align_ctrl #(.N_STREAMS(N), .MUX_FACTOR_BITS(2), .SYNC_PERIOD(SP), .MAX_SLIP(MS),
                     .PULSE_LEN(PL), .SETTLE_CYCLES(SC)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .sync(sync_v[1]), .advance(adv_v[1]),
        .delay(dly_v[1]), .aligned(aligned_v[1]), .fault(fault_v[1]),
        .fault_stream(fs_v[1]), .corrections(corr_v[1]));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ofs [2][N];          // cycles each stream lags stream 0, modulo SP
    bit present [2][N];
    int step [2] = '{1, 4};
    int adv_edges [2][N];
    int dly_edges [2][N];
    int hi_adv [2][N];
    int hi_dly [2][N];
    bit chk_width = 1'b1;
    int t = 0;

    bit exp_fault [2];
    int exp_fs    [2];
    int exp_corr  [2];
    int exp_adv   [2][N];
    int exp_dly   [2][N];

    task automatic check(string tag, int got, int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Offsetter model: each pulse edge slides the stream's frame by one step, syncs follow the phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            t++;
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < N; i++) begin
                    if (adv_v[d][i]) begin
                        if (hi_adv[d][i] == 0) begin
                            adv_edges[d][i]++;
                            ofs[d][i] = (ofs[d][i] - step[d] + SP) % SP;
                        end
                        hi_adv[d][i]++;
                    end else begin
                        if (hi_adv[d][i] != 0 && chk_width)
                            check($sformatf("d%0d_adv%0d_width", d, i), hi_adv[d][i], PL);
                        hi_adv[d][i] = 0;
                    end
                    if (dly_v[d][i]) begin
                        if (hi_dly[d][i] == 0) begin
                            dly_edges[d][i]++;
                            ofs[d][i] = (ofs[d][i] + step[d]) % SP;
                        end
                        hi_dly[d][i]++;
                    end else begin
                        if (hi_dly[d][i] != 0 && chk_width)
                            check($sformatf("d%0d_dly%0d_width", d, i), hi_dly[d][i], PL);
                        hi_dly[d][i] = 0;
                    end
                    sync_v[d][i] = present[d][i] && (((t % SP) - ofs[d][i] + SP) % SP == 0);
                end
            end
        end
    end

    // Expected outcome from the signed phase error of each stream.
    function automatic void predict(int d);
        int err, mag;
        bit bad;
        exp_fault[d] = !present[d][0];
        exp_fs[d]    = 0;
        exp_corr[d]  = 0;
        for (int i = 0; i < N; i++) begin
            exp_adv[d][i] = 0;
            exp_dly[d][i] = 0;
        end
        for (int i = 1; i < N; i++) begin
            err = (ofs[d][i] < SP / 2) ? ofs[d][i] : ofs[d][i] - SP;
            mag = (err < 0) ? -err : err;
            bad = !present[d][i] || (mag % step[d]) != 0 || (mag / step[d]) > MS;
            if (bad && !exp_fault[d]) begin
                exp_fault[d] = 1'b1;
                exp_fs[d]    = i;
            end
            if (err > 0) exp_adv[d][i] = mag / step[d];
            if (err < 0) exp_dly[d][i] = mag / step[d];
            exp_corr[d] += mag / step[d];
        end
        if (exp_fault[d]) begin
            exp_corr[d] = 0;
            for (int i = 0; i < N; i++) begin
                exp_adv[d][i] = 0;
                exp_dly[d][i] = 0;
            end
        end
    endfunction

    task automatic set_clean();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < N; i++) begin
                ofs[d][i]     = 0;
                present[d][i] = 1'b1;
            end
    endtask

    task automatic do_reset();
        enable = 1'b0;
        rst    = 1'b1;
        tick(3);
        rst = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < N; i++) begin
                adv_edges[d][i] = 0;
                dly_edges[d][i] = 0;
            end
    endtask

    task automatic run_case(string name);
        int k;
        predict(0);
        predict(1);
        do_reset();
        enable = 1'b1;
        k = 0;
        while (!((aligned_v[0] || fault_v[0]) && (aligned_v[1] || fault_v[1])) && k < 3000) begin
            tick(1);
            k++;
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_d%0d_done", name, d), int'(aligned_v[d] | fault_v[d]), 1);
            check($sformatf("%s_d%0d_fault", name, d), int'(fault_v[d]), int'(exp_fault[d]));
            check($sformatf("%s_d%0d_aligned", name, d), int'(aligned_v[d]), int'(!exp_fault[d]));
            if (exp_fault[d]) begin
                check($sformatf("%s_d%0d_fstream", name, d), int'(fs_v[d]), exp_fs[d]);
                check($sformatf("%s_d%0d_lines", name, d), int'(adv_v[d] | dly_v[d]), 0);
            end
            check($sformatf("%s_d%0d_corr", name, d), int'(corr_v[d]), exp_corr[d]);
            for (int i = 0; i < N; i++) begin
                check($sformatf("%s_d%0d_adv%0d", name, d, i), adv_edges[d][i], exp_adv[d][i]);
                check($sformatf("%s_d%0d_dly%0d", name, d, i), dly_edges[d][i], exp_dly[d][i]);
            end
        end
    endtask

    initial begin
        int k, mag;
        set_clean();
        do_reset();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_d%0d_adv", d), int'(adv_v[d]), 0);
            check($sformatf("rst_d%0d_dly", d), int'(dly_v[d]), 0);
            check($sformatf("rst_d%0d_aligned", d), int'(aligned_v[d]), 0);
            check($sformatf("rst_d%0d_fault", d), int'(fault_v[d]), 0);
            check($sformatf("rst_d%0d_fstream", d), int'(fs_v[d]), 0);
            check($sformatf("rst_d%0d_corr", d), int'(corr_v[d]), 0);
        end

        set_clean();
        run_case("aligned");

        set_clean();
        ofs[0][2] = 3;
        ofs[1][1] = SP - 8;
        run_case("late_early");

        set_clean();
        ofs[0][1] = 20;
        ofs[1][1] = SP - 6;
        run_case("slip_frac");

        set_clean();
        present[0][3] = 1'b0;
        present[1][0] = 1'b0;
        run_case("missing");

        set_clean();
        ofs[0][3] = SP - 12;
        ofs[0][1] = 12;
        ofs[1][2] = SP - 48;
        run_case("edge_slip");

        for (int r = 0; r < 8; r++) begin
            set_clean();
            for (int i = 1; i < N; i++) begin
                mag = int'($urandom_range(0, 14));
                ofs[0][i] = ($urandom_range(0, 1) != 0) ? (SP - mag) % SP : mag;
                mag = int'($urandom_range(0, 13)) * 4 / (($urandom_range(0, 4) == 0) ? 3 : 4);
                ofs[1][i] = ($urandom_range(0, 1) != 0) ? (SP - mag) % SP : mag;
            end
            run_case($sformatf("rand%0d", r));
        end

        set_clean();
        run_case("prelock");
        ofs[0][2] = 1;
        k = 0;
        while (aligned_v[0] && k < 3 * SP) begin
            tick(1);
            k++;
        end
        check("lock_drop", int'(aligned_v[0]), 0);
`ifdef DTS_ALIGN_CTRL_AUTORELOCK_EN
        k = 0;
        while (!aligned_v[0] && k < 3000) begin
            tick(1);
            k++;
        end
        check("relock_aligned", int'(aligned_v[0]), 1);
        check("relock_adv2", adv_edges[0][2], 1);
        check("relock_corr", int'(corr_v[0]), 1);
`else
        tick(4 * SP);
        check("hold_aligned", int'(aligned_v[0]), 0);
        check("hold_adv2", adv_edges[0][2], 0);
        check("hold_corr", int'(corr_v[0]), 0);
`endif

        set_clean();
        ofs[0][2] = 5;
        do_reset();
        chk_width = 1'b0;
        enable = 1'b1;
        k = 0;
        while (!adv_v[0][2] && k < 1000) begin
            tick(1);
            k++;
        end
        check("midcorr_pulse_seen", int'(adv_v[0][2]), 1);
        tick(1);
        enable = 1'b0;
        tick(1);
        check("midcorr_adv", int'(adv_v[0]), 0);
        check("midcorr_dly", int'(dly_v[0]), 0);
        check("midcorr_aligned", int'(aligned_v[0]), 0);
        tick(3 * SP);
        check("idle_adv_edges", adv_edges[0][2], 1);
        check("idle_corr", int'(corr_v[0]), 1);
        chk_width = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
